loss_target_feeder: RTL

Sits directly upstream of the loss stage. It holds one batch of target values (Y) per output column, and pairs each activation (H) leaving the systolic array with its matching target. It then presents aligned H/Y/valid triples to the two loss columns.
Each column is tracked with its own row pointer, so the systolic array's inter-column skew passes through unchanged.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/column_tracker.sv | 70 +++++++
 rtl/loss_target_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the loss-stage feeder: default word width,
// default target-memory depth and the pass-level state encoding.
package tpu_pkg;

    localparam int TPU_DATA_W    = 16;
    localparam int TPU_MAX_BATCH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/column_tracker.sv
// Per-column tracker: walks a row pointer through the target memory,
// pairs each accepted activation with its target one cycle later and
// flags valids that arrive when the column cannot take them.
module column_tracker
    import tpu_pkg::*;
#(
    parameter int DATA_W    = TPU_DATA_W,
    parameter int MAX_BATCH = TPU_MAX_BATCH,
    localparam int PTR_W    = $clog2(MAX_BATCH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     active,
    input  logic                     clear,
    input  logic [PTR_W:0]           size,
    input  logic signed [DATA_W-1:0] h_in,
    input  logic                     vld_in,
    input  logic signed [DATA_W-1:0] y_rd,
    output logic [PTR_W-1:0]         ptr,
    output logic                     col_done,
    output logic signed [DATA_W-1:0] h_out,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     vld_out,
    output logic                     overrun
);

    logic signed [DATA_W-1:0] h_p1;
    logic signed [DATA_W-1:0] y_p1;
    logic                     vld_p1;
    logic                     accept;
    logic [PTR_W:0]           last_idx;

    // A sample is taken only while the pass runs and this column still owes rows;
    // anything else on the valid line is an overrun.
    assign accept   = vld_in & active & ~col_done;
    assign overrun  = vld_in & ~(active & ~col_done);
    assign last_idx = size - 1'b1;

    // Pointer/done bookkeeping plus the single output stage; data holds when no sample is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            col_done <= 1'b0;
            vld_p1   <= 1'b0;
            h_p1     <= '0;
            y_p1     <= '0;
        end else begin
            // stage p0 -> p1: capture activation with its target
            vld_p1 <= accept;
            if (accept) begin
                h_p1 <= h_in;
                y_p1 <= y_rd;
            end
            if (clear) begin
                ptr      <= '0;
                col_done <= 1'b0;
            end else if (accept) begin
                ptr <= ptr + 1'b1;
                if ({1'b0, ptr} == last_idx) begin
                    col_done <= 1'b1;
                end
            end
        end
    end

    assign h_out   = h_p1;
    assign y_out   = y_p1;
    assign vld_out = vld_p1;

endmodule

// File: rtl/loss_target_feeder.sv
// Holds one batch of targets per output column and presents aligned
// activation/target/valid triples to the two loss columns. Each column
// owns its own pointer so the array's inter-column skew is preserved.
module loss_target_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W    = TPU_DATA_W,
    parameter int MAX_BATCH = TPU_MAX_BATCH,
    localparam int PTR_W    = $clog2(MAX_BATCH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [PTR_W-1:0]         load_row,
    input  logic signed [DATA_W-1:0] load_y1,
    input  logic signed [DATA_W-1:0] load_y2,
    input  logic [PTR_W:0]           batch_size_in,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] H_1_in,
    input  logic signed [DATA_W-1:0] H_2_in,
    input  logic                     valid_1_in,
    input  logic                     valid_2_in,
    output logic signed [DATA_W-1:0] H_1_out,
    output logic signed [DATA_W-1:0] Y_1_out,
    output logic                     valid_1_out,
    output logic signed [DATA_W-1:0] H_2_out,
    output logic signed [DATA_W-1:0] Y_2_out,
    output logic                     valid_2_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overrun,
    output logic                     err_cfg
);

    localparam logic [PTR_W:0] MAX_SIZE = (PTR_W+1)'(MAX_BATCH);

    state_t                   state;
    logic [PTR_W:0]           size_q;
    logic signed [DATA_W-1:0] mem_y1 [MAX_BATCH];
    logic signed [DATA_W-1:0] mem_y2 [MAX_BATCH];

    logic                     in_idle;
    logic                     size_ok;
    logic                     start_ok;
    logic                     start_bad;
    logic                     load_ok;
    logic [PTR_W-1:0]         ptr_1;
    logic [PTR_W-1:0]         ptr_2;
    logic                     col_done_1;
    logic                     col_done_2;
    logic                     ovr_1;
    logic                     ovr_2;
    logic signed [DATA_W-1:0] y_rd_1;
    logic signed [DATA_W-1:0] y_rd_2;

    assign in_idle   = (state == IDLE);
    assign size_ok   = (batch_size_in != '0) && (batch_size_in <= MAX_SIZE);
    assign start_ok  = start & in_idle & size_ok;
    assign start_bad = start & in_idle & ~size_ok;
    assign load_ok   = load_en & in_idle & ({1'b0, load_row} < MAX_SIZE);

    // Target memory: written only in IDLE, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_y1[load_row] <= load_y1;
            mem_y2[load_row] <= load_y2;
        end
    end

    assign y_rd_1 = mem_y1[ptr_1];
    assign y_rd_2 = mem_y2[ptr_2];

    // Pass sequencing with registered busy/done and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            size_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cfg     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        size_q  <= batch_size_in;
                        err_cfg <= 1'b0;
                    end else if (start_bad) begin
                        err_cfg <= 1'b1;
                    end
                end
                RUN: begin
                    if (col_done_1 && col_done_2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
            // a legal start wins over an overrun seen in the same cycle
            if (start_ok) begin
                err_overrun <= 1'b0;
            end else if (ovr_1 || ovr_2) begin
                err_overrun <= 1'b1;
            end
        end
    end

    column_tracker #(
        .DATA_W    (DATA_W),
        .MAX_BATCH (MAX_BATCH)
    ) u_col_1 (
        .clk      (clk),
        .rst      (rst),
        .active   (state == RUN),
        .clear    (start_ok),
        .size     (size_q),
        .h_in     (H_1_in),
        .vld_in   (valid_1_in),
        .y_rd     (y_rd_1),
        .ptr      (ptr_1),
        .col_done (col_done_1),
        .h_out    (H_1_out),
        .y_out    (Y_1_out),
        .vld_out  (valid_1_out),
        .overrun  (ovr_1)
    );

    column_tracker #(
        .DATA_W    (DATA_W),
        .MAX_BATCH (MAX_BATCH)
    ) u_col_2 (
        .clk      (clk),
        .rst      (rst),
        .active   (state == RUN),
        .clear    (start_ok),
        .size     (size_q),
        .h_in     (H_2_in),
        .vld_in   (valid_2_in),
        .y_rd     (y_rd_2),
        .ptr      (ptr_2),
        .col_done (col_done_2),
        .h_out    (H_2_out),
        .y_out    (Y_2_out),
        .vld_out  (valid_2_out),
        .overrun  (ovr_2)
    );

endmodule
